// File: rtl/fb_arb_if.sv
// fb_arb_if: request/ack, scan-out read and RAM macro signals of the frame-buffer arbiter
interface fb_arb_if #(
    parameter int AW = 13,
    parameter int DW = 8
);
    logic          arb_en;
    logic          w0_req;
    logic          w0_ack;
    logic [AW-1:0] w0_addr;
    logic [DW-1:0] w0_data;
    logic          w1_req;
    logic          w1_ack;
    logic [AW-1:0] w1_addr;
    logic [DW-1:0] w1_data;
    logic          rd_req;
    logic          rd_ack;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data;
    logic          ram_cs;
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata;
    logic [DW-1:0] ram_rdata;
    logic          addr_err;
    modport slave (
        input  arb_en, w0_req, w0_addr, w0_data, w1_req, w1_addr, w1_data, rd_req, rd_addr, ram_rdata,
        output w0_ack, w1_ack, rd_ack, rd_data, ram_cs, ram_we, ram_addr, ram_wdata, addr_err
    );
    modport master (
        output arb_en, w0_req, w0_addr, w0_data, w1_req, w1_addr, w1_data, rd_req, rd_addr, ram_rdata,
        input  w0_ack, w1_ack, rd_ack, rd_data, ram_cs, ram_we, ram_addr, ram_wdata, addr_err
    );
endinterface

// File: rtl/fb_arb.sv
// fb_arb: single-port frame-buffer RAM arbiter, two round-robin writers plus priority scan-out reader; FB_ARB_STAT_EN adds write/error counters
module fb_arb #(
    parameter int AW       = 13,
    parameter int DW       = 8,
    parameter int FB_DEPTH = 4800
) (
    input  logic        clk,
    input  logic        rst,
`ifdef FB_ARB_STAT_EN
    input  logic        stat_clr,
    output logic [15:0] stat_wr_cnt,
    output logic [7:0]  stat_err_cnt,
`endif
    fb_arb_if.slave     bus
);
    typedef enum logic [2:0] {IDLE, WR0, WR1, RD, RDV, RDA} state_t;
    state_t state;
    logic   rr;
    logic   oor;
    logic   w0_oor, w1_oor, rd_oor;
    assign w0_oor = bus.w0_addr >= AW'(FB_DEPTH);
    assign w1_oor = bus.w1_addr >= AW'(FB_DEPTH);
    assign rd_oor = bus.rd_addr >= AW'(FB_DEPTH);
    // arbitration and access sequencing; out-of-range accesses run the same states with the RAM kept deselected
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            rr            <= 1'b0;
            oor           <= 1'b0;
            bus.ram_cs    <= 1'b0;
            bus.ram_we    <= 1'b0;
            bus.ram_addr  <= '0;
            bus.ram_wdata <= '0;
            bus.w0_ack    <= 1'b0;
            bus.w1_ack    <= 1'b0;
            bus.rd_ack    <= 1'b0;
            bus.rd_data   <= '0;
            bus.addr_err  <= 1'b0;
        end else begin
            bus.ram_cs   <= 1'b0;
            bus.ram_we   <= 1'b0;
            bus.w0_ack   <= 1'b0;
            bus.w1_ack   <= 1'b0;
            bus.rd_ack   <= 1'b0;
            bus.addr_err <= 1'b0;
            case (state)
                IDLE: if (bus.arb_en) begin
                    if (bus.rd_req) begin
                        state        <= RD;
                        oor          <= rd_oor;
                        bus.ram_cs   <= !rd_oor;
                        bus.ram_addr <= bus.rd_addr;
                    end else if (bus.w0_req && (!bus.w1_req || !rr)) begin
                        state         <= WR0;
                        rr            <= 1'b1;
                        oor           <= w0_oor;
                        bus.ram_cs    <= !w0_oor;
                        bus.ram_we    <= !w0_oor;
                        bus.ram_addr  <= bus.w0_addr;
                        bus.ram_wdata <= bus.w0_data;
                        bus.w0_ack    <= 1'b1;
                        bus.addr_err  <= w0_oor;
                    end else if (bus.w1_req) begin
                        state         <= WR1;
                        rr            <= 1'b0;
                        oor           <= w1_oor;
                        bus.ram_cs    <= !w1_oor;
                        bus.ram_we    <= !w1_oor;
                        bus.ram_addr  <= bus.w1_addr;
                        bus.ram_wdata <= bus.w1_data;
                        bus.w1_ack    <= 1'b1;
                        bus.addr_err  <= w1_oor;
                    end
                end
                RD: state <= RDV;
                RDV: begin
                    state        <= RDA;
                    bus.rd_data  <= oor ? DW'(0) : bus.ram_rdata;
                    bus.rd_ack   <= 1'b1;
                    bus.addr_err <= oor;
                end
                default: state <= IDLE;
            endcase
        end
    end
`ifdef FB_ARB_STAT_EN
    // wrapping count of in-range write commits, saturating count of address errors
    always_ff @(posedge clk) begin
        if (rst || stat_clr) begin
            stat_wr_cnt  <= '0;
            stat_err_cnt <= '0;
        end else begin
            if ((state == WR0 || state == WR1) && !oor) stat_wr_cnt <= stat_wr_cnt + 16'd1;
            if (bus.addr_err && stat_err_cnt != 8'hFF) stat_err_cnt <= stat_err_cnt + 8'd1;
        end
    end
`endif
endmodule

// File: tb/tb_fb_arb.sv
// tb_fb_arb: vector table plus corner sequences for fb_arb, acks checked against a scoreboard queue
module tb_fb_arb;
    typedef struct {
        int          kind;
        logic [12:0] addr;
        logic [7:0]  data;
        logic        err;
    } exp_t;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic stat_clr = 1'b0;
`ifdef FB_ARB_STAT_EN
    logic [15:0] stat_wr_cnt;
    logic [7:0]  stat_err_cnt;
`endif
    int   checks = 0;
    int   errors = 0;
    int   err_pulses = 0;
    int   acks_total = 0;
    bit   cs_seen = 0;
    exp_t sb[$];
    exp_t vec[10];
    logic [7:0] mem[8192];
    fb_arb_if #(.AW(13), .DW(8)) bus();
    fb_arb dut (
        .clk(clk),
        .rst(rst),
`ifdef FB_ARB_STAT_EN
        .stat_clr(stat_clr),
        .stat_wr_cnt(stat_wr_cnt),
        .stat_err_cnt(stat_err_cnt),
`endif
        .bus(bus)
    );
    always #5 clk = ~clk;
    always @(posedge clk) begin
        if (bus.ram_cs && bus.ram_we) mem[bus.ram_addr] <= bus.ram_wdata;
        if (bus.ram_cs && !bus.ram_we) bus.ram_rdata <= mem[bus.ram_addr];
    end
    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", nm, got, exp);
        end
    endtask
    always @(negedge clk) if (!rst) begin
        int   k;
        int   n;
        exp_t e;
        if (bus.ram_cs) cs_seen = 1;
        if (bus.addr_err) err_pulses++;
        n = int'(bus.w0_ack) + int'(bus.w1_ack) + int'(bus.rd_ack);
        acks_total += n;
        if (n > 1) chk("double_ack", n, 1);
        if (n != 0) begin
            if (sb.size() == 0) chk("unexpected_ack", n, 0);
            else begin
                e = sb.pop_front();
                k = bus.w0_ack ? 0 : bus.w1_ack ? 1 : 2;
                chk("sb_port", k, e.kind);
                chk("sb_addr_err", bus.addr_err, e.err);
                if (k == 2) chk("sb_rd_data", bus.rd_data, e.data);
                else begin
                    chk("sb_cs", bus.ram_cs, !e.err);
                    chk("sb_we", bus.ram_we, !e.err);
                    if (!e.err) begin
                        chk("sb_ram_addr", bus.ram_addr, e.addr);
                        chk("sb_ram_wdata", bus.ram_wdata, e.data);
                    end
                end
            end
        end
    end
    task automatic drop(input int kind);
        if (kind == 0) bus.w0_req = 0;
        else if (kind == 1) bus.w1_req = 0;
        else bus.rd_req = 0;
    endtask
    task automatic wait_ack(input int kind, input int exp_n);
        int n = 0;
        bit hit = 0;
        while (!hit && n < 20) begin
            @(negedge clk);
            n++;
            hit = kind == 0 ? bus.w0_ack : kind == 1 ? bus.w1_ack : bus.rd_ack;
        end
        chk("ack_latency", n, exp_n);
        @(posedge clk); #1;
        drop(kind);
    endtask
    task automatic do_access(input exp_t v);
        if (v.kind == 0) begin bus.w0_addr = v.addr; bus.w0_data = v.data; bus.w0_req = 1; end
        else if (v.kind == 1) begin bus.w1_addr = v.addr; bus.w1_data = v.data; bus.w1_req = 1; end
        else begin bus.rd_addr = v.addr; bus.rd_req = 1; end
        cs_seen = 0;
        sb.push_back(v);
        wait_ack(v.kind, v.kind == 2 ? 4 : 2);
        chk("cs_during_access", cs_seen, !v.err);
    endtask
    function automatic logic [34:0] outs();
        return {bus.ram_cs, bus.ram_we, bus.ram_addr, bus.ram_wdata, bus.w0_ack, bus.w1_ack,
                bus.rd_ack, bus.rd_data, bus.addr_err};
    endfunction
    initial begin
        int wr = 0;
        int a0, a1, r0, r1, got, last, trd, tw, acks0;
        for (int i = 0; i < 8192; i++) mem[i] = 8'h00;
        bus.ram_rdata = 0;
        bus.arb_en = 1;
        bus.w0_req = 0; bus.w0_addr = 0; bus.w0_data = 0;
        bus.w1_req = 0; bus.w1_addr = 0; bus.w1_data = 0;
        bus.rd_req = 0; bus.rd_addr = 0;
        vec[0] = '{0, 13'h0028, 8'hA5, 1'b0};
        vec[1] = '{1, 13'h0000, 8'h11, 1'b0};
        vec[2] = '{0, 13'h12BF, 8'h3C, 1'b0};
        vec[3] = '{2, 13'h0028, 8'hA5, 1'b0};
        vec[4] = '{2, 13'h0000, 8'h11, 1'b0};
        vec[5] = '{2, 13'h12BF, 8'h3C, 1'b0};
        vec[6] = '{1, 13'h12C0, 8'h77, 1'b1};
        vec[7] = '{2, 13'h1FFF, 8'h00, 1'b1};
        vec[8] = '{1, 13'h12BE, 8'h5A, 1'b0};
        vec[9] = '{2, 13'h12BE, 8'h5A, 1'b0};
        repeat (3) @(posedge clk);
        #1 rst = 0;
        @(negedge clk);
        chk("reset_outputs", outs(), 35'd0);
        @(posedge clk); #1;
        for (int i = 0; i < 10; i++) begin
            do_access(vec[i]);
            if (vec[i].kind != 2 && !vec[i].err) wr++;
            if (i == 0) begin
                @(negedge clk);
                chk("cs_after_write", bus.ram_cs, 0);
                @(posedge clk); #1;
            end
        end
        chk("addr_err_pulses", err_pulses, 2);
`ifdef FB_ARB_STAT_EN
        chk("stat_err_cnt", stat_err_cnt, 2);
        chk("stat_wr_cnt", stat_wr_cnt, wr);
        stat_clr = 1;
        @(posedge clk); #1 stat_clr = 0;
        chk("stat_clr", {stat_wr_cnt, stat_err_cnt}, 0);
`endif
        // both writers held: grants must alternate starting at w0, two cycles apart
        bus.w0_addr = 13'h0010; bus.w0_data = 8'h01;
        bus.w1_addr = 13'h0020; bus.w1_data = 8'h02;
        for (int i = 0; i < 4; i++) sb.push_back('{i % 2, i % 2 ? 13'h0020 : 13'h0010, i % 2 ? 8'h02 : 8'h01, 1'b0});
        bus.w0_req = 1; bus.w1_req = 1;
        got = 0; last = -1; r0 = 0; r1 = 0;
        for (int c = 0; c < 40 && got < 4; c++) begin
            @(negedge clk);
            a0 = bus.w0_ack; a1 = bus.w1_ack;
            if (a0 || a1) begin
                if (last >= 0) chk("rr_ack_gap", c - last, 2);
                last = c;
                got++;
            end
            if (r0 != 0) begin bus.w0_req = 1; r0 = 0; end
            if (r1 != 0) begin bus.w1_req = 1; r1 = 0; end
            @(posedge clk); #1;
            if (a0 != 0) begin bus.w0_req = 0; r0 = got < 4 ? 1 : 0; end
            if (a1 != 0) begin bus.w1_req = 0; r1 = got < 4 ? 1 : 0; end
        end
        chk("rr_ack_count", got, 4);
        bus.w0_req = 0; bus.w1_req = 0;
        // read and write raised together: read wins, write follows
        sb.push_back('{2, 13'h12BF, 8'h3C, 1'b0});
        sb.push_back('{0, 13'h0100, 8'h99, 1'b0});
        bus.rd_addr = 13'h12BF; bus.rd_req = 1;
        bus.w0_addr = 13'h0100; bus.w0_data = 8'h99; bus.w0_req = 1;
        trd = -1; tw = -1;
        for (int c = 0; c < 9; c++) begin
            @(negedge clk);
            a0 = bus.w0_ack; a1 = bus.rd_ack;
            if (c == 1) chk("rd_first", {bus.ram_cs, bus.ram_we, bus.ram_addr}, {1'b1, 1'b0, 13'h12BF});
            if (a1 != 0) trd = c;
            if (a0 != 0) tw = c;
            @(posedge clk); #1;
            if (a1 != 0) bus.rd_req = 0;
            if (a0 != 0) bus.w0_req = 0;
        end
        chk("rd_ack_cycle", trd, 3);
        chk("w0_after_rd_cycle", tw, 5);
        // reset during the RD cycle aborts the read; the held request is served again
        bus.rd_addr = 13'h0028; bus.rd_req = 1;
        @(negedge clk);
        @(negedge clk);
        chk("rd_cycle_cs", bus.ram_cs, 1);
        rst = 1;
        @(posedge clk); #1 rst = 0;
        @(negedge clk);
        chk("mid_reset_outputs", outs(), 35'd0);
        sb.push_back('{2, 13'h0028, 8'hA5, 1'b0});
        wait_ack(2, 3);
`ifdef FB_ARB_STAT_EN
        chk("stat_after_reset", {stat_wr_cnt, stat_err_cnt}, 0);
`endif
        // arb_en dropped mid-read: the read finishes, then no new grant until re-enabled
        sb.push_back('{2, 13'h0000, 8'h11, 1'b0});
        bus.rd_addr = 13'h0000; bus.rd_req = 1;
        @(posedge clk); #1 bus.arb_en = 0;
        wait_ack(2, 3);
        bus.w0_addr = 13'h0200; bus.w0_data = 8'h42; bus.w0_req = 1;
        cs_seen = 0;
        acks0 = acks_total;
        repeat (10) @(posedge clk);
        #1;
        chk("disabled_cs", cs_seen, 0);
        chk("disabled_acks", acks_total - acks0, 0);
        bus.arb_en = 1;
        sb.push_back('{0, 13'h0200, 8'h42, 1'b0});
        wait_ack(0, 2);
        repeat (2) @(posedge clk);
        chk("scoreboard_empty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
